pipeline_scoreboard: RTL

Parametrised hazard-detection and forwarding-control block for the in-order ARM pipeline. It replaces the fixed two-source, EXE/MEM-only hazard and forwarding pair. It tracks destination registers of in-flight instructions through DEPTH post-decode slots, raises a load-use or no-forwarding stall toward IF/ID, and registers per-source forwarding selects that the EXE stage applies one cycle later. It sits beside the ID stage and takes the global memory-not-ready freeze and the branch flush.

---
 rtl/scoreboard_pkg.sv | 19 +
 rtl/scoreboard_src_match.sv | 41 ++++
 rtl/pipeline_scoreboard.sv | 106 ++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - slot entry type, forwarding constants and select-width helper
package scoreboard_pkg;

   // Wide enough for any register file up to 256 entries; narrower ids are zero-extended.
   localparam int DEST_W     = 8;
   localparam int FWD_SEL_RF = 0;

   typedef struct packed {
      logic              valid;
      logic              wb_en;
      logic [DEST_W-1:0] dest;
      logic              mem_read;
   } slot_t;

   function automatic int sel_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/scoreboard_src_match.sv
// rtl/scoreboard_src_match.sv - match one source operand against the forwardable slots
module scoreboard_src_match
   import scoreboard_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int REG_AW = 4,
   parameter int SEL_W  = 2
) (
   input  logic              src_valid,
   input  logic [REG_AW-1:0] src,
   input  slot_t [DEPTH-2:0] slots,
   output logic              hit,
   output logic              load_hit,
   output logic [SEL_W-1:0]  slot_idx
);

   logic [DEPTH-2:0] match;
   logic             youngest_load;

   for (genvar i = 0; i < DEPTH-1; i++) begin : g_match
      assign match[i] = src_valid & slots[i].valid & slots[i].wb_en
                      & (slots[i].dest == DEST_W'(src));
   end

   // Scan oldest to youngest so the lowest matching slot is the one left behind.
   always_comb begin
      hit           = 1'b0;
      slot_idx      = '0;
      youngest_load = 1'b0;
      for (int i = DEPTH-2; i >= 0; i--) begin
         if (match[i]) begin
            hit           = 1'b1;
            slot_idx      = SEL_W'(i);
            youngest_load = slots[i].mem_read;
         end
      end
   end

   assign load_hit = hit & (slot_idx == '0) & youngest_load;

endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - hazard detection and forwarding-select scoreboard beside ID
// Optional stall counter: SCOREBOARD_STALL_CNT_EN (undefined ties stall_cnt to 0).
module pipeline_scoreboard
   import scoreboard_pkg::*;
#(
   parameter  int NUM_REGS = 16,
   parameter  int DEPTH    = 3,
   parameter  int NUM_SRC  = 2,
   parameter  int CNT_W    = 16,
   localparam int REG_AW   = $clog2(NUM_REGS),
   localparam int SEL_W    = sel_width(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      freeze,
   input  logic                      flush,
   input  logic                      id_valid,
   input  logic                      id_wb_en,
   input  logic [REG_AW-1:0]         id_dest,
   input  logic                      id_mem_read,
   input  logic [NUM_SRC-1:0]        id_src_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic                      en_forwarding,
   output logic                      stall,
   output logic [NUM_SRC*SEL_W-1:0]  exe_fwd_sel,
   output logic [CNT_W-1:0]          stall_cnt
);

   // The WB slot writes a write-first register file, so nothing ever needs to read it back;
   // only slots 0..DEPTH-2 hold state.
   localparam int NSLOT = DEPTH - 1;

   slot_t [NSLOT-1:0]        slots;
   slot_t                    id_entry;
   logic [NUM_SRC-1:0]       hit;
   logic [NUM_SRC-1:0]       load_hit;
   logic [NUM_SRC*SEL_W-1:0] slot_idx;
   logic                     hazard;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      scoreboard_src_match #(
         .DEPTH  (DEPTH),
         .REG_AW (REG_AW),
         .SEL_W  (SEL_W)
      ) u_match (
         .src_valid (id_src_valid[s]),
         .src       (id_src[s*REG_AW +: REG_AW]),
         .slots     (slots),
         .hit       (hit[s]),
         .load_hit  (load_hit[s]),
         .slot_idx  (slot_idx[s*SEL_W +: SEL_W])
      );
   end

   assign hazard = en_forwarding ? (|load_hit) : (|hit);
   assign stall  = hazard & id_valid & ~flush;

   // A producer in slot i has advanced to slot i+1 by the time the consumer is in EXE.
   always_comb begin
      fwd_sel_d = {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
      if (en_forwarding && id_valid && !flush && !stall) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (hit[s]) begin
               fwd_sel_d[s*SEL_W +: SEL_W] = slot_idx[s*SEL_W +: SEL_W] + SEL_W'(1);
            end
         end
      end
   end

   always_comb begin
      id_entry = '0;
      if (id_valid && !stall && !flush) begin
         id_entry.valid    = 1'b1;
         id_entry.wb_en    = id_wb_en;
         id_entry.dest     = DEST_W'(id_dest);
         id_entry.mem_read = id_mem_read;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slots       <= '0;
         exe_fwd_sel <= {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
      end else if (!freeze) begin
         slots[0] <= id_entry;
         for (int i = 1; i < NSLOT; i++) begin
            slots[i] <= slots[i-1];
         end
         exe_fwd_sel <= fwd_sel_d;
      end
   end

`ifdef SCOREBOARD_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall && !freeze && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule
